// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation sequencer: state codes and default timings.
package irrigation_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFill     = 3'd1,
        StWater    = 3'd2,
        StCooldown = 3'd3,
        StAlarm    = 3'd4
    } state_e;

    localparam int unsigned WaterCyclesDef    = 8;
    localparam int unsigned FillTimeoutDef    = 16;
    localparam int unsigned CooldownCyclesDef = 4;

    // A run may only begin when asked for, the soil is dry and it is not raining.
    function automatic logic start_ok(input logic start, input logic dry, input logic rain);
        return start && dry && !rain;
    endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Sensor/command inputs and actuator/status outputs of the irrigation sequencer.
interface irrigation_sequencer_if;

    logic       start;
    logic       dry;
    logic       rain;
    logic       tank_low;
    logic       tank_full;
    logic       alarm_ack;
    logic       valve;
    logic       pump;
    logic       busy;
    logic       alarm;
    logic [2:0] state;

    // Controller side: drives requests and sensors, observes actuators.
    modport master (
        output start, dry, rain, tank_low, tank_full, alarm_ack,
        input  valve, pump, busy, alarm, state
    );

    // Sequencer side.
    modport slave (
        input  start, dry, rain, tank_low, tank_full, alarm_ack,
        output valve, pump, busy, alarm, state
    );

endinterface

// File: rtl/cycle_timer.sv
// Saturating up-counter: clear has priority, counts while enabled, holds at LIMIT-1.
module cycle_timer #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LastCount = W'(LIMIT - 1);
    localparam logic [W-1:0] One = W'(1);

    logic [W-1:0] count_q, count_d;

    // Next count: clear, else step unless already at the last value.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LastCount)) begin
            count_d = count_q + One;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == LastCount);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: optional tank fill, timed watering, cooldown, fill-timeout alarm.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned WATER_CYCLES    = WaterCyclesDef,
    parameter int unsigned FILL_TIMEOUT    = FillTimeoutDef,
    parameter int unsigned COOLDOWN_CYCLES = CooldownCyclesDef
) (
    input logic                   clk,
    input logic                   rst_n,
    irrigation_sequencer_if.slave bus
);

    state_e state_q, state_d;
    logic   valve_q, valve_d;
    logic   pump_q, pump_d;
    logic   busy_q, busy_d;
    logic   alarm_q, alarm_d;
    logic   water_done, fill_done, cool_done;

    // Water progress survives a refill; it is only restarted from IDLE.
    cycle_timer #(.LIMIT(WATER_CYCLES)) u_water_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == StIdle),
        .en_i   (state_q == StWater),
        .done_o (water_done)
    );

    // Every fill attempt gets a fresh timeout window.
    cycle_timer #(.LIMIT(FILL_TIMEOUT)) u_fill_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != StFill),
        .en_i   (state_q == StFill),
        .done_o (fill_done)
    );

    cycle_timer #(.LIMIT(COOLDOWN_CYCLES)) u_cool_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != StCooldown),
        .en_i   (state_q == StCooldown),
        .done_o (cool_done)
    );

    // Next state and the Moore outputs that go with it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok(bus.start, bus.dry, bus.rain)) begin
                    state_d = bus.tank_low ? StFill : StWater;
                end
            end
            StFill: begin
                // A full tank wins over a simultaneous timeout.
                if (bus.tank_full) begin
                    state_d = StWater;
                end else if (fill_done) begin
                    state_d = StAlarm;
                end
            end
            StWater: begin
                // Rain aborts first; a finished run does not bother refilling.
                if (bus.rain || water_done) begin
                    state_d = StCooldown;
                end else if (bus.tank_low) begin
                    state_d = StFill;
                end
            end
            StCooldown: begin
                if (cool_done) begin
                    state_d = StIdle;
                end
            end
            StAlarm: begin
                if (bus.alarm_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        valve_d = (state_d == StWater);
        pump_d  = (state_d == StFill);
        busy_d  = (state_d != StIdle);
        alarm_d = (state_d == StAlarm);
    end

    // State register with registered outputs kept in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valve_q <= 1'b0;
            pump_q  <= 1'b0;
            busy_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            busy_q  <= busy_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.valve = valve_q;
    assign bus.pump  = pump_q;
    assign bus.busy  = busy_q;
    assign bus.alarm = alarm_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with default timing parameters.
module tb_irrigation_sequencer;

    // Expected {valve, pump, busy, alarm, state[2:0]} per state.
    localparam logic [6:0] OIdle  = 7'b0000_000;
    localparam logic [6:0] OFill  = 7'b0110_001;
    localparam logic [6:0] OWater = 7'b1010_010;
    localparam logic [6:0] OCool  = 7'b0010_011;
    localparam logic [6:0] OAlarm = 7'b0011_100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irrigation_sequencer_if bus ();

    irrigation_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.valve, bus.pump, bus.busy, bus.alarm, bus.state};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] exp);
        tick();
        chk(tag, exp);
    endtask

    task automatic run(input string tag, input logic [6:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, exp);
        end
    endtask

    // Valve and pump must never be driven together.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(bus.valve && bus.pump)) else begin
                errors++;
                $error("FAIL exclusive: observed valve=%b pump=%b required not both 1",
                       bus.valve, bus.pump);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dry       = 1'b0;
        bus.rain      = 1'b0;
        bus.tank_low  = 1'b0;
        bus.tank_full = 1'b0;
        bus.alarm_ack = 1'b0;

        #12;
        chk("reset_state", OIdle);
        rst_n = 1'b1;

        // Plain run: 8 watering cycles, 4 cooldown cycles, back to idle.
        bus.start = 1'b1;
        bus.dry   = 1'b1;
        step("basic_enter_water", OWater);
        bus.start = 1'b0;
        run("basic_water", OWater, 7);
        run("basic_cool", OCool, 4);
        step("basic_idle", OIdle);

        // Start ignored while raining or when soil is wet.
        bus.start = 1'b1;
        bus.rain  = 1'b1;
        step("rain_blocks_start", OIdle);
        bus.rain = 1'b0;
        bus.dry  = 1'b0;
        step("wet_blocks_start", OIdle);
        bus.start = 1'b0;
        bus.dry   = 1'b1;

        // Fill first, tank full on the 5th pump cycle, then a full watering run.
        bus.tank_low = 1'b1;
        bus.start    = 1'b1;
        step("fill_enter", OFill);
        bus.start = 1'b0;
        run("fill_pump", OFill, 4);
        bus.tank_full = 1'b1;
        bus.tank_low  = 1'b0;
        step("fill_to_water", OWater);
        bus.tank_full = 1'b0;
        run("fill_water", OWater, 7);
        run("fill_cool", OCool, 4);
        step("fill_idle", OIdle);

        // Fill timeout: 16 pump cycles then alarm, start ignored, ack returns to idle.
        bus.tank_low = 1'b1;
        bus.start    = 1'b1;
        step("to_enter", OFill);
        bus.start = 1'b0;
        run("to_pump", OFill, 15);
        step("to_alarm", OAlarm);
        bus.start = 1'b1;
        run("to_alarm_hold", OAlarm, 3);
        bus.start     = 1'b0;
        bus.alarm_ack = 1'b1;
        step("to_ack_idle", OIdle);
        bus.alarm_ack = 1'b0;

        // Tank full in the very cycle the timeout would fire: watering wins.
        bus.start = 1'b1;
        step("tie_enter", OFill);
        bus.start = 1'b0;
        run("tie_pump", OFill, 15);
        bus.tank_full = 1'b1;
        bus.tank_low  = 1'b0;
        step("tie_to_water", OWater);
        bus.tank_full = 1'b0;
        run("tie_water", OWater, 7);
        run("tie_cool", OCool, 4);
        step("tie_idle", OIdle);

        // Rain with tank low in the 3rd watering cycle: cooldown, never pump.
        bus.start = 1'b1;
        step("rain_enter", OWater);
        bus.start = 1'b0;
        run("rain_water", OWater, 2);
        bus.rain     = 1'b1;
        bus.tank_low = 1'b1;
        step("rain_abort", OCool);
        bus.rain     = 1'b0;
        bus.tank_low = 1'b0;
        run("rain_cool", OCool, 3);
        step("rain_idle", OIdle);

        // Refill mid-run with dry dropping: watering resumes, 8 valve cycles in total.
        bus.start = 1'b1;
        step("refill_enter", OWater);
        bus.start = 1'b0;
        bus.dry   = 1'b0;
        run("refill_water_a", OWater, 2);
        bus.tank_low = 1'b1;
        step("refill_fill", OFill);
        bus.tank_low = 1'b0;
        step("refill_fill2", OFill);
        bus.tank_full = 1'b1;
        step("refill_resume", OWater);
        bus.tank_full = 1'b0;
        run("refill_water_b", OWater, 4);
        step("refill_cool", OCool);
        run("refill_cool2", OCool, 3);
        step("refill_idle", OIdle);
        bus.dry = 1'b1;

        // Asynchronous reset mid-watering, start held through release.
        bus.start = 1'b1;
        step("rst_enter", OWater);
        run("rst_water", OWater, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", OIdle);
        tick();
        chk("rst_held", OIdle);
        #3;
        rst_n = 1'b1;
        step("rst_restart", OWater);
        bus.start = 1'b0;
        run("rst_water2", OWater, 7);
        run("rst_cool", OCool, 4);
        step("rst_idle", OIdle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
